// File: rtl/nv_nvdla_sdp_xrdma_reqgen.sv
// SDP read-DMA request generator.
// Walks a (surface, line, burst) cube of atoms and issues one read request
// per burst. Each request also pushes a context word to the egress side.
// Requests are issued only while the latency FIFO has enough atom credits
// to absorb the whole burst.
module nv_nvdla_sdp_xrdma_reqgen #(
  parameter  int AW        = 64,
  parameter  int MAX_BURST = 4,
  parameter  int LAT_DEPTH = 32,
  localparam int BL_W      = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1,
  localparam int CW        = $clog2(LAT_DEPTH + 1)
) (
  input  logic                nvdla_core_clk,
  input  logic                nvdla_core_rst,
  input  logic                op_load,
  input  logic [AW-1:0]       reg2dp_base_addr,
  input  logic [12:0]         reg2dp_width,
  input  logic [12:0]         reg2dp_height,
  input  logic [12:0]         reg2dp_surf_num,
  input  logic [AW-1:0]       reg2dp_line_stride,
  input  logic [AW-1:0]       reg2dp_surface_stride,
  input  logic                reg2dp_perf_dma_en,
  output logic                dma_rd_req_vld,
  input  logic                dma_rd_req_rdy,
  output logic [AW+BL_W-1:0]  dma_rd_req_pd,
  output logic                cq_pvld,
  input  logic                cq_prdy,
  output logic [BL_W:0]       cq_pd,
  input  logic                lat_fifo_pop,
  output logic                ig_done,
  output logic [CW-1:0]       credit_cnt,
  output logic                credit_err,
  output logic [31:0]         dp2reg_rdma_stall
);

  typedef enum logic {IDLE, REQ} state_t;

  state_t          state_reg;
  logic [AW-1:0]   addr_reg;         // address of the next burst
  logic [AW-1:0]   line_addr_reg;    // start of the current line
  logic [AW-1:0]   surf_addr_reg;    // start of the current surface
  logic [12:0]     rem_reg;          // atoms left in the current line, minus 1
  logic [12:0]     width_reg;
  logic [12:0]     height_reg;
  logic [12:0]     line_cnt_reg;     // lines left after this one
  logic [12:0]     surf_cnt_reg;     // surfaces left after this one
  logic [AW-1:0]   line_stride_reg;
  logic [AW-1:0]   surf_stride_reg;
  logic [CW-1:0]   credit_reg;
  logic            err_reg;
  logic            done_reg;
  logic [31:0]     stall_reg;

  logic [13:0]     off;
  logic [13:0]     room;
  logic [13:0]     rem_atoms;
  logic [13:0]     size;
  logic [BL_W-1:0] size_m1;
  logic            last_burst;
  logic            last_req;
  logic            in_req;
  logic            credit_ok;
  logic            fire;
  logic [31:0]     credit_next;
  logic            credit_ovf;
  logic [AW-1:0]   next_line_addr;
  logic [AW-1:0]   next_surf_addr;

  // Burst sizing, handshake qualification and credit arithmetic.
  always_comb begin
    off            = 14'(addr_reg & AW'(MAX_BURST - 1));
    room           = 14'(MAX_BURST) - off;
    rem_atoms      = {1'b0, rem_reg} + 14'd1;
    size           = (room < rem_atoms) ? room : rem_atoms;
    size_m1        = BL_W'(size - 14'd1);
    last_burst     = (size == rem_atoms);
    last_req       = last_burst && (line_cnt_reg == 13'd0) && (surf_cnt_reg == 13'd0);
    in_req         = (state_reg == REQ);
    credit_ok      = in_req && (32'(credit_reg) >= 32'(size));
    fire           = credit_ok && dma_rd_req_rdy && cq_prdy;
    credit_next    = 32'(credit_reg) - (fire ? 32'(size) : 32'd0)
                   + (lat_fifo_pop ? 32'd1 : 32'd0);
    credit_ovf     = lat_fifo_pop && !fire && (32'(credit_reg) == 32'(LAT_DEPTH));
    next_line_addr = line_addr_reg + line_stride_reg;
    next_surf_addr = surf_addr_reg + surf_stride_reg;
  end

  // Both channels see the other's ready so they always transfer together.
  assign dma_rd_req_vld    = credit_ok && cq_prdy;
  assign cq_pvld           = credit_ok && dma_rd_req_rdy;
  assign dma_rd_req_pd     = in_req ? {size_m1, addr_reg} : '0;
  assign cq_pd             = in_req ? {last_req, size_m1} : '0;
  assign ig_done           = done_reg;
  assign credit_cnt        = credit_reg;
  assign credit_err        = err_reg;
  assign dp2reg_rdma_stall = stall_reg;

  // Layer FSM and address walk: bursts inner, lines middle, surfaces outer.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      state_reg       <= IDLE;
      addr_reg        <= '0;
      line_addr_reg   <= '0;
      surf_addr_reg   <= '0;
      rem_reg         <= '0;
      width_reg       <= '0;
      height_reg      <= '0;
      line_cnt_reg    <= '0;
      surf_cnt_reg    <= '0;
      line_stride_reg <= '0;
      surf_stride_reg <= '0;
    end else if (state_reg == IDLE) begin
      if (op_load) begin
        state_reg       <= REQ;
        addr_reg        <= reg2dp_base_addr;
        line_addr_reg   <= reg2dp_base_addr;
        surf_addr_reg   <= reg2dp_base_addr;
        rem_reg         <= reg2dp_width;
        width_reg       <= reg2dp_width;
        height_reg      <= reg2dp_height;
        line_cnt_reg    <= reg2dp_height;
        surf_cnt_reg    <= reg2dp_surf_num;
        line_stride_reg <= reg2dp_line_stride;
        surf_stride_reg <= reg2dp_surface_stride;
      end
    end else if (fire) begin
      if (!last_burst) begin
        addr_reg <= addr_reg + AW'(size);
        rem_reg  <= rem_reg - size[12:0];
      end else if (line_cnt_reg != 13'd0) begin
        addr_reg      <= next_line_addr;
        line_addr_reg <= next_line_addr;
        rem_reg       <= width_reg;
        line_cnt_reg  <= line_cnt_reg - 13'd1;
      end else if (surf_cnt_reg != 13'd0) begin
        addr_reg      <= next_surf_addr;
        line_addr_reg <= next_surf_addr;
        surf_addr_reg <= next_surf_addr;
        rem_reg       <= width_reg;
        line_cnt_reg  <= height_reg;
        surf_cnt_reg  <= surf_cnt_reg - 13'd1;
      end else begin
        state_reg <= IDLE;
      end
    end
  end

  // Latency-FIFO credit tracking; a pop into a full pool is dropped and flagged.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      credit_reg <= CW'(LAT_DEPTH);
      err_reg    <= 1'b0;
    end else if (credit_ovf) begin
      err_reg <= 1'b1;
    end else begin
      credit_reg <= CW'(credit_next);
    end
  end

  // One-cycle done pulse following the final request of the layer.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) done_reg <= 1'b0;
    else                done_reg <= fire && last_req;
  end

  // Saturating count of cycles the DMA port back-pressured a valid request.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      stall_reg <= '0;
    end else if (state_reg == IDLE && op_load) begin
      stall_reg <= '0;
    end else if (reg2dp_perf_dma_en && dma_rd_req_vld && !dma_rd_req_rdy &&
                 stall_reg != 32'hFFFF_FFFF) begin
      stall_reg <= stall_reg + 32'd1;
    end
  end

endmodule
